// File: rtl/shift_sequencer.sv
// Command sequencer that drives an external shift register (load / shift / clear)
// and returns the register contents through a valid/ready response channel.
module shift_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             sr_clear,
  output logic             sr_shift_left,
  output logic             sr_shift_right,
  output logic [WIDTH-1:0] sr_parallel_in,
  input  logic [WIDTH-1:0] sr_parallel_out
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    SHIFT,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Shifting further than the register width always yields zero, so cap there.
  localparam logic [3:0] MAX_COUNT = (WIDTH > 15) ? 4'd15 : 4'(WIDTH);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] data_reg;
  logic [3:0]       count_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [3:0]       eff_count;

  always_comb begin
    eff_count = 4'd0;
    if (cmd_op == OP_LEFT || cmd_op == OP_RIGHT) begin
      eff_count = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= OP_LOAD;
      data_reg     <= '0;
      count_reg    <= 4'd0;
      rsp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cmd_valid) begin
        op_reg    <= cmd_op;
        data_reg  <= cmd_data;
        count_reg <= eff_count;
      end else if (state_reg == SHIFT) begin
        count_reg <= count_reg - 4'd1;
      end
      // The last shift landed on the preceding edge, so the register output is final here.
      if (state_reg == CAPTURE) begin
        rsp_data_reg <= sr_parallel_out;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    rsp_valid      = 1'b0;
    sr_clear       = 1'b0;
    sr_shift_left  = 1'b0;
    sr_shift_right = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_next = (cmd_op == OP_CLEAR) ? CLEAR : LOAD;
        end
      end
      LOAD: begin
        state_next = (count_reg != 4'd0) ? SHIFT : CAPTURE;
      end
      CLEAR: begin
        sr_clear   = 1'b1;
        state_next = CAPTURE;
      end
      SHIFT: begin
        sr_shift_left  = (op_reg == OP_LEFT);
        sr_shift_right = (op_reg == OP_RIGHT);
        if (count_reg <= 4'd1) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rsp_data       = rsp_data_reg;
  assign sr_parallel_in = data_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift register on the control side.
module tb_shift_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [3:0]       cmd_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             sr_clear;
  logic             sr_shift_left;
  logic             sr_shift_right;
  logic [WIDTH-1:0] sr_parallel_in;
  logic [WIDTH-1:0] sr_parallel_out;
  logic [WIDTH-1:0] sr_q;

  int checks = 0;
  int failures = 0;

  shift_sequencer #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .cmd_count      (cmd_count),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .sr_clear       (sr_clear),
    .sr_shift_left  (sr_shift_left),
    .sr_shift_right (sr_shift_right),
    .sr_parallel_in (sr_parallel_in),
    .sr_parallel_out(sr_parallel_out)
  );

  always #5 clk = ~clk;

  // External register: sync clear, shift with zero fill, otherwise parallel load.
  always_ff @(posedge clk) begin
    if (sr_clear) sr_q <= '0;
    else if (sr_shift_left) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    else if (sr_shift_right) sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    else sr_q <= sr_parallel_in;
  end
  assign sr_parallel_out = sr_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d, input logic [3:0] c);
    int n;
    n = (c > 4'd8) ? 8 : int'(c);
    case (op)
      2'b00:   return d;
      2'b01:   return (n >= 8) ? 8'h00 : 8'(d << n);
      2'b10:   return (n >= 8) ? 8'h00 : 8'(d >> n);
      default: return 8'h00;
    endcase
  endfunction

  // Issues one command from IDLE and follows it through to the response handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [3:0] c,
                         input logic [7:0] exp_data, input int exp_lat, input int exp_left,
                         input int exp_right, input int exp_clear, input int hold, input bit poke);
    int cyc, nl, nr, nc;
    check_eq("idle_cmd_ready", 32'(cmd_ready), 1);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = c;
    tick();
    cmd_valid = 1'b0;
    check_eq("accept_busy", 32'(busy), 1);
    check_eq("accept_cmd_ready", 32'(cmd_ready), 0);
    check_eq("par_in_latched", 32'(sr_parallel_in), 32'(d));
    cyc = 1; nl = 0; nr = 0; nc = 0;
    while (!rsp_valid && cyc < 40) begin
      nl += int'(sr_shift_left);
      nr += int'(sr_shift_right);
      nc += int'(sr_clear);
      check_eq("exclusive", 32'((sr_shift_left & sr_shift_right) |
                                (sr_clear & (sr_shift_left | sr_shift_right))), 0);
      tick();
      cyc++;
    end
    check_eq("rsp_valid_seen", 32'(rsp_valid), 1);
    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("rsp_data", 32'(rsp_data), 32'(exp_data));
    check_eq("left_pulses", 32'(nl), 32'(exp_left));
    check_eq("right_pulses", 32'(nr), 32'(exp_right));
    check_eq("clear_pulses", 32'(nc), 32'(exp_clear));
    if (poke) begin
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h0F; cmd_count = 4'd2;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("hold_rsp_data", 32'(rsp_data), 32'(exp_data));
      check_eq("hold_rsp_valid", 32'(rsp_valid), 1);
      check_eq("hold_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("post_rsp_valid", 32'(rsp_valid), 0);
    check_eq("post_busy", 32'(busy), 0);
    check_eq("post_cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b0;
    $display("txn op=%0d data=%02h count=%0d rsp=%02h cycles=%0d", op, d, c, rsp_data, cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_rsp_data"}, 32'(rsp_data), 0);
    check_eq({tag, "_par_in"}, 32'(sr_parallel_in), 0);
    check_eq({tag, "_ctrl"}, 32'({sr_clear, sr_shift_left, sr_shift_right}), 0);
  endtask

  initial begin
    logic [1:0] rop;
    logic [7:0] rd;
    logic [3:0] rc;
    int         rn;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    cmd_count = 4'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Directed vectors: op, data, count, expected result, latency, left, right, clear, hold, poke
    run_cmd(2'b01, 8'hB5, 4'd3,  8'hA8, 6,  3, 0, 0, 0, 1'b0);
    run_cmd(2'b10, 8'hB5, 4'd12, 8'h00, 11, 0, 8, 0, 0, 1'b0);
    run_cmd(2'b00, 8'h3C, 4'd5,  8'h3C, 3,  0, 0, 0, 0, 1'b0);
    run_cmd(2'b11, 8'hFF, 4'd7,  8'h00, 3,  0, 0, 1, 0, 1'b0);
    run_cmd(2'b01, 8'hFF, 4'd8,  8'h00, 11, 8, 0, 0, 1, 1'b0);
    run_cmd(2'b10, 8'h80, 4'd0,  8'h80, 3,  0, 0, 0, 2, 1'b0);
    run_cmd(2'b01, 8'h81, 4'd9,  8'h00, 11, 8, 0, 0, 0, 1'b0);
    run_cmd(2'b10, 8'hB5, 4'd2,  8'h2D, 5,  0, 2, 0, 10, 1'b1);

    // Reset during the second SHIFT cycle must take effect without a clock edge.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h5A; cmd_count = 4'd6;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_shift_left", 32'(sr_shift_left), 1);
    check_eq("mid_shift_rsp_data", 32'(rsp_data), 32'h2D);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async");
    #2 reset = 1'b0;
    tick();
    run_cmd(2'b01, 8'h01, 4'd1, 8'h02, 4, 1, 0, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      rd  = 8'($urandom_range(0, 255));
      rc  = 4'($urandom_range(0, 15));
      rn  = (rop == 2'b01 || rop == 2'b10) ? ((rc > 4'd8) ? 8 : int'(rc)) : 0;
      run_cmd(rop, rd, rc, model(rop, rd, rc), rn + 3,
              (rop == 2'b01) ? rn : 0, (rop == 2'b10) ? rn : 0, (rop == 2'b11) ? 1 : 0,
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
